byte_packer: RTL and testbench



---
 rtl/byte_packer_pkg.sv | 11 +
 rtl/byte_packer_idle.sv | 34 +++
 rtl/byte_packer.sv | 107 ++++++++++
 tb/tb_byte_packer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/byte_packer_pkg.sv
// Shared constants and helpers for the byte_packer write-side packing stage.
package byte_packer_pkg;

  localparam int TIMEOUT_CYCLES_DEFAULT = 255;

  // Width of a count that must hold 0..n inclusive.
  function automatic int nbytes_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/byte_packer_idle.sv
// idle_timer: saturating idle counter with synchronous clear and done flag.
// Compiled only when BYTE_PACKER_TIMEOUT_EN is defined.
`ifdef BYTE_PACKER_TIMEOUT_EN
module idle_timer
  import byte_packer_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_cg,
  input  logic i_clear,
  output logic o_done
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count;

  assign o_done = (count == W'(LIMIT));

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count <= '0;
    end else if (i_cg) begin
      if (i_clear)      count <= '0;
      else if (!o_done) count <= count + W'(1);
    end
  end

endmodule
`endif

// File: rtl/byte_packer.sv
// byte_packer: gathers BYTE_W-bit symbols into N_BYTES-wide words with a lane count.
// Define BYTE_PACKER_TIMEOUT_EN to add an automatic flush after TIMEOUT_CYCLES idle cycles.
module byte_packer
  import byte_packer_pkg::*;
#(
  parameter int BYTE_W         = 8,
  parameter int N_BYTES        = 4,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_cg,
  input  logic [BYTE_W-1:0]                    i_data,
  input  logic                                 i_valid,
  output logic                                 o_ready,
  input  logic                                 i_flush,
  output logic [N_BYTES*BYTE_W-1:0]            o_data,
  output logic [nbytes_width(N_BYTES)-1:0]     o_nBytes,
  output logic                                 o_valid,
  input  logic                                 i_ready
);

  localparam int CNT_W = nbytes_width(N_BYTES);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_BYTES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_BYTES - 1);

  typedef logic [N_BYTES-1:0][BYTE_W-1:0] lanes_t;

  if (BYTE_W < 1 || N_BYTES < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("byte_packer: illegal parameter combination");
  end

  lanes_t           acc;
  lanes_t           merged;
  lanes_t           out_lanes;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] fill_next;
  logic             flush_pend;
  logic             flush_req;
  logic             push;
  logic             out_free;
  logic             complete;

  assign o_ready   = (cnt < CNT_FULL);
  assign push      = i_valid && o_ready;
  assign out_free  = !o_valid || i_ready;
  assign fill_next = cnt + CNT_W'(push);
  assign o_data    = out_lanes;

`ifdef BYTE_PACKER_TIMEOUT_EN
  logic timeout;

  idle_timer #(.LIMIT(TIMEOUT_CYCLES)) u_idle_timer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_cg    (i_cg),
    .i_clear (push || (cnt == '0)),
    .o_done  (timeout)
  );

  assign flush_req = flush_pend || i_flush || timeout;
`else
  assign flush_req = flush_pend || i_flush;
`endif

  assign complete = (push && (cnt == CNT_LAST)) || (cnt == CNT_FULL) ||
                    (flush_req && ((cnt != '0) || push));

  // Accumulator view including this cycle's symbol, if any.
  always_comb begin
    merged = acc;
    for (int i = 0; i < N_BYTES; i++) begin
      if (push && (cnt == CNT_W'(i))) merged[i] = i_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // NOTE: the accumulator is reset (and cleared on every load) because the
      // unused lanes of an emitted word rely on it holding zeros above cnt.
      acc        <= '0;
      cnt        <= '0;
      flush_pend <= 1'b0;
      out_lanes  <= '0;
      o_nBytes   <= '0;
      o_valid    <= 1'b0;
    end else if (i_cg) begin
      if (complete && out_free) begin
        out_lanes  <= merged;
        o_nBytes   <= fill_next;
        o_valid    <= 1'b1;
        acc        <= '0;
        cnt        <= '0;
        flush_pend <= 1'b0;
      end else begin
        if (push) begin
          acc <= merged;
          cnt <= fill_next;
        end
        if (o_valid && i_ready) o_valid <= 1'b0;
        // A flush only stays pending while there is something to emit.
        flush_pend <= complete && flush_req;
      end
    end
  end

endmodule

// File: tb/tb_byte_packer.sv
// Self-checking bench for byte_packer: directed scenarios plus randomized
// traffic checked against a symbol-queue reference model.
module tb_byte_packer;

  localparam int BYTE_W  = 8;
  localparam int N_BYTES = 4;
  localparam int NB_W    = 3;
  localparam int T_CYC   = 5;

  logic                      i_clk = 1'b0;
  logic                      i_rst = 1'b1;
  logic                      i_cg = 1'b1;
  logic [BYTE_W-1:0]         i_data = '0;
  logic                      i_valid = 1'b0;
  logic                      o_ready;
  logic                      i_flush = 1'b0;
  logic [N_BYTES*BYTE_W-1:0] o_data;
  logic [NB_W-1:0]           o_nBytes;
  logic                      o_valid;
  logic                      i_ready = 1'b0;

  always #5 i_clk = ~i_clk;

  byte_packer #(
    .BYTE_W         (BYTE_W),
    .N_BYTES        (N_BYTES),
    .TIMEOUT_CYCLES (T_CYC)
  ) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_cg     (i_cg),
    .i_data   (i_data),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_flush  (i_flush),
    .o_data   (o_data),
    .o_nBytes (o_nBytes),
    .o_valid  (o_valid),
    .i_ready  (i_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: every accepted symbol, in order, not yet seen in an output word.
  logic [BYTE_W-1:0]         sym_q[$];
  bit                        strict_full = 0;
  bit                        stall_armed = 0;
  logic [N_BYTES*BYTE_W-1:0] prev_data;
  logic [NB_W-1:0]           prev_nb;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Word leaving the DUT: its valid lanes must be the oldest pending symbols.
  task automatic take_word();
    logic [BYTE_W-1:0] exp_b;
    check("nbytes_nonzero", 64'(o_nBytes != 0), 64'd1);
    check("nbytes_le_n", 64'(o_nBytes <= N_BYTES), 64'd1);
    if (strict_full) check("nbytes_full", 64'(o_nBytes), 64'(N_BYTES));
    for (int i = 0; i < N_BYTES; i++) begin
      if (i < int'(o_nBytes)) begin
        check("symbol_available", 64'(sym_q.size() > 0), 64'd1);
        if (sym_q.size() > 0) begin
          exp_b = sym_q.pop_front();
          check("lane_data", 64'(o_data[i*BYTE_W +: BYTE_W]), 64'(exp_b));
        end
      end else begin
        check("lane_zero", 64'(o_data[i*BYTE_W +: BYTE_W]), 64'd0);
      end
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input int v, input int d, input int f, input int r);
    if (stall_armed) begin
      check("stall_valid", 64'(o_valid), 64'd1);
      check("stall_data", 64'(o_data), 64'(prev_data));
      check("stall_nbytes", 64'(o_nBytes), 64'(prev_nb));
    end
    i_valid = (v != 0);
    i_data  = BYTE_W'(d);
    i_flush = (f != 0);
    i_ready = (r != 0);
    stall_armed = o_valid && (r == 0);
    prev_data   = o_data;
    prev_nb     = o_nBytes;
    if (i_valid && o_ready) sym_q.push_back(BYTE_W'(d));
    if (o_valid && i_ready) take_word();
    @(negedge i_clk);
    i_valid = 1'b0;
    i_flush = 1'b0;
  endtask

  task automatic drain();
    step(0, 0, 1, 1);
    for (int k = 0; k < 8 && (o_valid || sym_q.size() > 0); k++) step(0, 0, 0, 1);
    check("drain_model_empty", 64'(sym_q.size()), 64'd0);
    check("drain_out_idle", 64'(o_valid), 64'd0);
  endtask

  task automatic random_phase(input int cycles, input int flush_mod);
    for (int c = 0; c < cycles; c++) begin
      step(($urandom % 4) != 0, $urandom, (flush_mod > 0) && (($urandom % flush_mod) == 0),
           ($urandom % 3) != 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepted;
    int waited;
    bit seen;

    repeat (2) @(negedge i_clk);
    check("reset_valid", 64'(o_valid), 64'd0);
    check("reset_data", 64'(o_data), 64'd0);
    check("reset_nbytes", 64'(o_nBytes), 64'd0);
    check("reset_ready", 64'(o_ready), 64'd1);
    i_rst = 1'b0;
    @(negedge i_clk);

    // Continuous stream, output always ready.
    for (int i = 1; i <= 8; i++) begin
      check("stream_ready", 64'(o_ready), 64'd1);
      step(1, i, 0, 1);
      if (i == 4 || i == 8) begin
        check("stream_valid", 64'(o_valid), 64'd1);
        check("stream_word", 64'(o_data), (i == 4) ? 64'h04030201 : 64'h08070605);
        check("stream_nbytes", 64'(o_nBytes), 64'd4);
      end
    end
    step(0, 0, 0, 1);
    check("stream_done", 64'(o_valid), 64'd0);

    // Partial word on flush; flush of an empty accumulator emits nothing.
    step(1, 'hAA, 0, 1);
    step(1, 'hBB, 0, 1);
    step(0, 0, 1, 1);
    check("flush_valid", 64'(o_valid), 64'd1);
    check("flush_word", 64'(o_data), 64'h0000BBAA);
    check("flush_nbytes", 64'(o_nBytes), 64'd2);
    step(0, 0, 0, 1);
    step(0, 0, 1, 1);
    for (int k = 0; k < 3; k++) begin
      check("empty_flush_no_word", 64'(o_valid), 64'd0);
      step(0, 0, 0, 1);
    end

    // Backpressure: exactly N_BYTES more symbols fit behind a stalled word.
    for (int i = 0; i < 4; i++) step(1, 'h10 + i, 0, 1);
    check("bp_first_word", 64'(o_data), 64'h13121110);
    accepted = 0;
    for (int k = 0; k < 6; k++) begin
      if (o_ready) accepted++;
      step(1, 'h20 + k, 0, 0);
    end
    check("bp_accepted", 64'(accepted), 64'd4);
    check("bp_ready_low", 64'(o_ready), 64'd0);
    step(0, 0, 0, 1);
    check("bp_back_to_back_valid", 64'(o_valid), 64'd1);
    check("bp_second_word", 64'(o_data), 64'h23222120);
    step(0, 0, 0, 1);
    check("bp_done", 64'(o_valid), 64'd0);

    // Flush while stalled with three lanes filled, then a fourth symbol joins.
    for (int i = 0; i < 4; i++) step(1, 'h30 + i, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 'h40 + i, 0, 0);
    step(0, 0, 1, 0);
    check("pend_old_word_held", 64'(o_data), 64'h33323130);
    step(1, 'h43, 0, 0);
    step(0, 0, 0, 1);
    check("pend_word_valid", 64'(o_valid), 64'd1);
    check("pend_word", 64'(o_data), 64'h43424140);
    check("pend_nbytes", 64'(o_nBytes), 64'd4);
    step(0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      check("pend_no_empty_word", 64'(o_valid), 64'd0);
      step(0, 0, 0, 1);
    end
    step(1, 'h50, 0, 1);
    for (int k = 0; k < 2; k++) begin
      check("pend_cleared", 64'(o_valid), 64'd0);
      step(0, 0, 0, 1);
    end
    drain();

    // Idle timeout (or its absence).
    step(1, 'h5A, 0, 1);
    waited = 0;
    seen   = 0;
    for (int k = 0; k < 20; k++) begin
      if (o_valid) begin
        seen = 1;
        break;
      end
      waited++;
      step(0, 0, 0, 1);
    end
`ifdef BYTE_PACKER_TIMEOUT_EN
    check("timeout_word_seen", 64'(seen), 64'd1);
    check("timeout_latency", 64'(waited >= 4 && waited <= 8), 64'd1);
    check("timeout_nbytes", 64'(o_nBytes), 64'd1);
    step(0, 0, 0, 1);
`else
    check("no_timeout_word", 64'(seen), 64'd0);
`endif
    drain();

    // Clock gate low: a ready output word must not be consumed.
    for (int i = 0; i < 4; i++) step(1, 'h60 + i, 0, 1);
    i_cg    = 1'b0;
    i_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      check("cg_hold_valid", 64'(o_valid), 64'd1);
      check("cg_hold_data", 64'(o_data), 64'h63626160);
    end
    i_cg = 1'b1;
    step(0, 0, 0, 1);
    check("cg_release_taken", 64'(o_valid), 64'd0);

    // Asynchronous reset mid-word with a word pending at the output.
    for (int i = 0; i < 4; i++) step(1, 'h70 + i, 0, 1);
    step(1, 'h80, 0, 0);
    step(1, 'h81, 0, 0);
    check("prereset_valid", 64'(o_valid), 64'd1);
    #2 i_rst = 1'b1;
    #1;
    check("midreset_valid", 64'(o_valid), 64'd0);
    check("midreset_data", 64'(o_data), 64'd0);
    check("midreset_nbytes", 64'(o_nBytes), 64'd0);
    check("midreset_ready", 64'(o_ready), 64'd1);
    sym_q.delete();
    stall_armed = 0;
    @(negedge i_clk);
    i_rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1, 'h90 + i, 0, 1);
    check("postreset_word", 64'(o_data), 64'h93929190);
    step(0, 0, 0, 1);

    // Randomized traffic: full words only without flush, then with flushes.
`ifndef BYTE_PACKER_TIMEOUT_EN
    strict_full = 1;
`endif
    random_phase(1500, 0);
    strict_full = 0;
    drain();
    random_phase(1500, 12);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
